cv32e40x_wb_stage: RTL

- Final (writeback) pipeline stage, directly downstream of the execute stage.
- Consumes the EX/WB pipeline register.
- Completes loads from the LSU response channel, aligns, sign-extends and merges split (misaligned) loads, then drives the register-file write port and the CSR write strobe.
- Generates the stage-level ready/valid back to EX and the controller, and an instruction-retire pulse.

---
 rtl/cv32e40x_pkg.sv | 51 +++++
 rtl/cv32e40x_load_align.sv | 46 ++++
 rtl/cv32e40x_wb_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cv32e40x_pkg.sv
// Shared types for the writeback slice of the cv32e40x core.
//   lsu_size_e       : LSU access size encoding
//   csr_opcode_e     : CSR operation encoding
//   wb_split_state_e : writeback split-load tracking state
//   ex_wb_pipe_t     : EX/WB pipeline register
//   ctrl_fsm_t       : controller-to-pipeline control bundle (WB subset)
package cv32e40x_pkg;

  localparam int unsigned REGFILE_ADDR_W = 5;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_opcode_e;

  typedef enum logic [0:0] {
    WB_IDLE = 1'b0,
    WB_HOLD = 1'b1
  } wb_split_state_e;

  typedef struct packed {
    logic                      instr_valid;
    logic                      rf_we;
    logic [REGFILE_ADDR_W-1:0] rf_waddr;
    logic [31:0]               rf_wdata;
    logic                      lsu_en;
    lsu_size_e                 lsu_size;
    logic                      lsu_sext;
    logic [1:0]                lsu_addr_lsb;
    logic                      lsu_split_first;
    logic                      csr_en;
    csr_opcode_e               csr_op;
    logic [11:0]               csr_addr;
    logic [31:0]               csr_wdata;
    logic                      illegal_insn;
  } ex_wb_pipe_t;

  typedef struct packed {
    logic kill_wb;
    logic halt_wb;
  } ctrl_fsm_t;

endpackage

// File: rtl/cv32e40x_load_align.sv
// Combinational load data alignment: shift the word-aligned response down to the
// access offset, optionally merge with the held first half of a split access,
// then zero/sign-extend to 32 bits according to the access size.
//   rdata      : response word from the LSU
//   hold       : first-half data captured by the writeback stage
//   size       : access size
//   sext       : sign-extend when set, zero-extend otherwise
//   addr_lsb   : byte offset of the access
//   merge      : second half of a split access; combine with hold
//   first_half : rdata shifted down by the byte offset (captured for split loads)
//   value      : final 32-bit register-file value
module cv32e40x_load_align
  import cv32e40x_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] hold,
  input  lsu_size_e   size,
  input  logic        sext,
  input  logic [1:0]  addr_lsb,
  input  logic        merge,
  output logic [31:0] first_half,
  output logic [31:0] value
);

  logic [5:0]  shamt_lo;
  logic [5:0]  shamt_hi;
  logic [31:0] upper;
  logic [31:0] word;

  assign shamt_lo   = {1'b0, addr_lsb, 3'b000};
  // Offset 0 gives a 32-bit shift, which clears the upper contribution.
  assign shamt_hi   = 6'd32 - shamt_lo;
  assign first_half = rdata >> shamt_lo;
  assign upper      = rdata << shamt_hi;
  assign word       = merge ? (hold | upper) : first_half;

  always_comb begin
    value = word;
    unique case (size)
      LSU_BYTE: value = {{24{sext & word[7]}}, word[7:0]};
      LSU_HALF: value = {{16{sext & word[15]}}, word[15:0]};
      default:  value = word;
    endcase
  end

endmodule

// File: rtl/cv32e40x_wb_stage.sv
// Writeback stage: completes loads from the LSU response channel (including
// two-part misaligned loads), drives the register-file and CSR write ports,
// reports bus errors and produces the stage handshake and retire pulse.
// Optional feature macro: CV32E40X_WB_INSTRET_CNT_EN enables a free-running
// retire counter on instret_cnt_o; otherwise instret_cnt_o is tied to 0.
//   clk, rst                       : clock, asynchronous active-high reset
//   ex_wb_pipe_i, ctrl_fsm_i       : EX/WB pipe register, controller kill/halt
//   lsu_rvalid_i/rdata_i/err_i     : LSU response channel
//   rf_we_o/waddr_o/wdata_o        : register-file write port
//   csr_we_o/addr_o/wdata_o        : CSR write port
//   lsu_err_o                      : bus-error report to controller
//   wb_ready_o, wb_valid_o         : stage handshake
//   instret_o, instret_cnt_o       : retire pulse and optional count
module cv32e40x_wb_stage
  import cv32e40x_pkg::*;
#(
  parameter int unsigned RF_ADDR_W = 5,
  parameter int unsigned INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  ex_wb_pipe_t          ex_wb_pipe_i,
  input  ctrl_fsm_t            ctrl_fsm_i,
  input  logic                 lsu_rvalid_i,
  input  logic [31:0]          lsu_rdata_i,
  input  logic                 lsu_err_i,
  output logic                 rf_we_o,
  output logic [RF_ADDR_W-1:0] rf_waddr_o,
  output logic [31:0]          rf_wdata_o,
  output logic                 csr_we_o,
  output logic [11:0]          csr_addr_o,
  output logic [31:0]          csr_wdata_o,
  output logic                 lsu_err_o,
  output logic                 wb_ready_o,
  output logic                 wb_valid_o,
  output logic                 instret_o,
  output logic [INSTRET_W-1:0] instret_cnt_o
);

  wb_split_state_e state_q;
  logic [31:0]     hold_q;
  logic            err_q;

  logic        valid;
  logic        wait_rsp;
  logic        lsu_done;
  logic        err_any;
  logic        final_part;
  logic [31:0] first_half;
  logic [31:0] load_value;

  assign valid      = ex_wb_pipe_i.instr_valid && !ctrl_fsm_i.kill_wb && !ctrl_fsm_i.halt_wb;
  assign wait_rsp   = valid && ex_wb_pipe_i.lsu_en && !lsu_rvalid_i;
  assign wb_ready_o = ctrl_fsm_i.kill_wb || (!ctrl_fsm_i.halt_wb && !wait_rsp);
  assign wb_valid_o = valid && (!ex_wb_pipe_i.lsu_en || lsu_rvalid_i);

  assign lsu_done   = wb_valid_o && ex_wb_pipe_i.lsu_en;
  // err_q is only ever set while in HOLD, so it carries the first-half error.
  assign err_any    = lsu_err_i || err_q;
  // The first half of a split access never writes, retires or reports errors.
  assign final_part = !ex_wb_pipe_i.lsu_split_first;

  cv32e40x_load_align u_load_align (
    .rdata      (lsu_rdata_i),
    .hold       (hold_q),
    .size       (ex_wb_pipe_i.lsu_size),
    .sext       (ex_wb_pipe_i.lsu_sext),
    .addr_lsb   (ex_wb_pipe_i.lsu_addr_lsb),
    .merge      (state_q == WB_HOLD),
    .first_half (first_half),
    .value      (load_value)
  );

  assign rf_waddr_o  = RF_ADDR_W'(ex_wb_pipe_i.rf_waddr);
  assign rf_wdata_o  = ex_wb_pipe_i.lsu_en ? load_value : ex_wb_pipe_i.rf_wdata;
  assign rf_we_o     = wb_valid_o && ex_wb_pipe_i.rf_we && final_part &&
                       !(ex_wb_pipe_i.lsu_en && err_any);
  assign lsu_err_o   = lsu_done && final_part && err_any;
  assign csr_we_o    = wb_valid_o && ex_wb_pipe_i.csr_en && (ex_wb_pipe_i.csr_op != CSR_OP_READ);
  assign csr_addr_o  = ex_wb_pipe_i.csr_addr;
  assign csr_wdata_o = ex_wb_pipe_i.csr_wdata;
  assign instret_o   = wb_valid_o && final_part && !ex_wb_pipe_i.illegal_insn && !lsu_err_o;

  // Split-load tracking. wb_valid_o already excludes kill and halt, so a halted
  // stage falls through every branch and keeps its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WB_IDLE;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else if (ctrl_fsm_i.kill_wb) begin
      state_q <= WB_IDLE;
      err_q   <= 1'b0;
    end else if (lsu_done) begin
      if (ex_wb_pipe_i.lsu_split_first) begin
        state_q <= WB_HOLD;
        hold_q  <= first_half;
        err_q   <= lsu_err_i;
      end else if (state_q == WB_HOLD) begin
        state_q <= WB_IDLE;
        err_q   <= 1'b0;
      end
    end
  end

`ifdef CV32E40X_WB_INSTRET_CNT_EN
  logic [INSTRET_W-1:0] instret_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_cnt_q <= '0;
    end else if (instret_o) begin
      instret_cnt_q <= instret_cnt_q + INSTRET_W'(1);
    end
  end

  assign instret_cnt_o = instret_cnt_q;
`else
  assign instret_cnt_o = '0;
`endif

`ifndef SYNTHESIS
  // A response without an LSU instruction in WB is a controller protocol error.
  rsp_without_lsu : assert property (@(posedge clk) disable iff (rst)
    lsu_rvalid_i |-> (ex_wb_pipe_i.instr_valid && ex_wb_pipe_i.lsu_en));
`endif

endmodule
